tiny_sequencer: RTL



---
 rtl/tinycpu_pkg.sv | 29 ++
 rtl/tiny_sequencer_bus_split.sv | 23 ++
 rtl/tiny_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tinycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinycpu_pkg
// Description : Shared widths, opcode constants and sequencer state encoding
//               for the TinyCPU fetch/decode/execute controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tinycpu_pkg;

    // Datapath widths
    localparam int INSTR_W = 12;
    localparam int ADDR_W  = 8;
    localparam int OP_W    = 4;

    // Control-flow opcodes handled inside the sequencer
    localparam logic [OP_W-1:0] OP_JZ   = 4'hD;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // Sequencer state encoding
    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] c_st_idle   = 3'd0;
    localparam logic [ST_W-1:0] c_st_fetch  = 3'd1;
    localparam logic [ST_W-1:0] c_st_decode = 3'd2;
    localparam logic [ST_W-1:0] c_st_exec   = 3'd3;
    localparam logic [ST_W-1:0] c_st_halted = 3'd4;

endpackage : tinycpu_pkg
`default_nettype wire

// File: rtl/tiny_sequencer_bus_split.sv
`default_nettype none
// ============================================================================
// Module      : BusSplit
// Description : Splits an instruction word into its opcode (upper OP_W bits)
//               and operand (remaining low bits).
//   i_bus : instruction word
//   o_hi  : opcode field
//   o_lo  : operand field
// Revision    : 1.0 - initial release
// ============================================================================
module BusSplit
    import tinycpu_pkg::*;
(
    input  logic [INSTR_W-1:0]      i_bus,
    output logic [OP_W-1:0]         o_hi,
    output logic [INSTR_W-OP_W-1:0] o_lo
);

    assign o_hi = i_bus[INSTR_W-1:INSTR_W-OP_W];
    assign o_lo = i_bus[INSTR_W-OP_W-1:0];

endmodule : BusSplit
`default_nettype wire

// File: rtl/tiny_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tiny_sequencer
// Description : Fetch/decode/execute controller for TinyCPU. Owns the program
//               counter and instruction register, resolves JMP/JZ/HALT
//               locally and hands every other opcode to the datapath over a
//               req/ack handshake.
//   CLK, RST_N          : clock, synchronous active-low reset
//   RUN, LOAD, LOAD_ADDR: run enable, PC preset (IDLE only)
//   MEM_RD, ADDR        : fetch request / address (held until MEM_VALID)
//   MEM_VALID, MEM_DATA : fetch response
//   T, G                : opcode / operand from the instruction register
//   EXEC_REQ, EXEC_ACK  : datapath handshake
//   ZERO                : datapath zero flag, sampled in DECODE for JZ
//   BUSY, HALTED, PC    : status
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_sequencer
    import tinycpu_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RUN,
    input  logic               LOAD,
    input  logic [ADDR_W-1:0]  LOAD_ADDR,
    output logic               MEM_RD,
    output logic [ADDR_W-1:0]  ADDR,
    input  logic               MEM_VALID,
    input  logic [INSTR_W-1:0] MEM_DATA,
    output logic [OP_W-1:0]    T,
    output logic [ADDR_W-1:0]  G,
    output logic               EXEC_REQ,
    input  logic               EXEC_ACK,
    input  logic               ZERO,
    output logic               BUSY,
    output logic               HALTED,
    output logic [ADDR_W-1:0]  PC
);

    logic [ST_W-1:0]    r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_mem_rd;
    logic               r_exec_req;
    logic               r_busy;
    logic               r_halted;

    logic [ST_W-1:0]    w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               w_ir_ld;
    logic [OP_W-1:0]    w_t;
    logic [ADDR_W-1:0]  w_g;

    BusSplit u_bus_split (
        .i_bus (r_ir),
        .o_hi  (w_t),
        .o_lo  (w_g)
    );

    // Next-state / next-PC selection
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_ld     = 1'b0;
        case (r_state)
            c_st_idle: begin
                // LOAD wins over RUN; RUN is re-evaluated on the next cycle
                if (LOAD) begin
                    w_pc_nxt = LOAD_ADDR;
                end else if (RUN) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (MEM_VALID) begin
                    w_ir_ld     = 1'b1;
                    w_pc_nxt    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_state_nxt = c_st_decode;
                end
            end
            c_st_decode: begin
                case (w_t)
                    OP_HALT: w_state_nxt = c_st_halted;
                    OP_JMP: begin
                        w_pc_nxt    = w_g;
                        w_state_nxt = RUN ? c_st_fetch : c_st_idle;
                    end
                    OP_JZ: begin
                        if (ZERO) begin
                            w_pc_nxt = w_g;
                        end
                        w_state_nxt = RUN ? c_st_fetch : c_st_idle;
                    end
                    // ALU opcodes always execute; RUN is checked at the end
                    default: w_state_nxt = c_st_exec;
                endcase
            end
            c_st_exec: begin
                if (EXEC_ACK) begin
                    w_state_nxt = RUN ? c_st_fetch : c_st_idle;
                end
            end
            c_st_halted: begin
                if (!RUN) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // State, PC, IR and status outputs; outputs decode the next state so
    // they switch on the same edge that enters or leaves a state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= c_st_idle;
            r_pc       <= '0;
            r_ir       <= '0;
            r_mem_rd   <= 1'b0;
            r_exec_req <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            if (w_ir_ld) begin
                r_ir <= MEM_DATA;
            end
            r_mem_rd   <= (w_state_nxt == c_st_fetch);
            r_exec_req <= (w_state_nxt == c_st_exec);
            r_busy     <= (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_halted);
            r_halted   <= (w_state_nxt == c_st_halted);
        end
    end

    assign MEM_RD   = r_mem_rd;
    assign ADDR     = r_pc;
    assign PC       = r_pc;
    assign T        = w_t;
    assign G        = w_g;
    assign EXEC_REQ = r_exec_req;
    assign BUSY     = r_busy;
    assign HALTED   = r_halted;

endmodule : tiny_sequencer
`default_nettype wire
